// File: rtl/main_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : main_controller_if
// Purpose  : Control bundle between the RV32I main control FSM and the
//            multi-cycle datapath / memory. The master side is the controller;
//            the slave side is the datapath, which supplies the opcode and
//            memory handshake.
// Revision : 1.0 - initial release
// ============================================================================
interface main_controller_if #(
    parameter int RET_CNT_WIDTH = 32
);
    logic [6:0]               opcode;
    logic                     mem_ready;
    logic [1:0]               alu_op;
    logic [1:0]               alu_src_a;
    logic [1:0]               alu_src_b;
    logic [1:0]               pc_source;
    logic                     pc_write;
    logic                     pc_write_cond;
    logic                     i_or_d;
    logic                     mem_read;
    logic                     mem_write;
    logic                     ir_write;
    logic                     reg_write;
    logic [1:0]               mem_to_reg;
    logic                     illegal;
    logic                     retire;
    logic [RET_CNT_WIDTH-1:0] ret_count;

    modport master (
        input  opcode, mem_ready,
        output alu_op, alu_src_a, alu_src_b, pc_source, pc_write, pc_write_cond,
               i_or_d, mem_read, mem_write, ir_write, reg_write, mem_to_reg,
               illegal, retire, ret_count
    );

    modport slave (
        output opcode, mem_ready,
        input  alu_op, alu_src_a, alu_src_b, pc_source, pc_write, pc_write_cond,
               i_or_d, mem_read, mem_write, ir_write, reg_write, mem_to_reg,
               illegal, retire, ret_count
    );
endinterface
`default_nettype wire

// File: rtl/main_controller.sv
`default_nettype none
// ============================================================================
// Module   : main_controller
// Purpose  : Multi-cycle RV32I main control FSM. Sequences fetch, decode,
//            execute, memory and writeback; generates datapath enables and
//            the ALU_CONTROLLER alu_op; stalls on mem_ready; flags illegal
//            opcodes (sticky) and counts retired instructions.
// Revision : 1.0 - initial release
// ============================================================================
module main_controller #(
    parameter int RET_CNT_WIDTH = 32
) (
    input  wire logic         clk,
    input  wire logic         reset,
    main_controller_if.master bus
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC_R   = 4'd7,
        S_EXEC_I   = 4'd8,
        S_UPPER    = 4'd9,
        S_ALU_WB   = 4'd10,
        S_BRANCH   = 4'd11,
        S_JAL      = 4'd12,
        S_JALR     = 4'd13,
        S_TRAP     = 4'd14
    } state_t;

    state_t                   state;
    state_t                   next_state;

    // Moore outputs are registered from the state being entered, so they are
    // valid from the first cycle of each state and clear with the async reset.
    logic [1:0]               alu_op_q;
    logic [1:0]               src_a_q;
    logic [1:0]               src_b_q;
    logic [1:0]               pc_source_q;
    logic                     pc_write_q;
    logic                     pc_write_cond_q;
    logic                     i_or_d_q;
    logic                     mem_read_q;
    logic                     mem_write_q;
    logic                     reg_write_q;
    logic [1:0]               mem_to_reg_q;
    logic                     retire_q;
    logic                     illegal_q;
    logic [RET_CNT_WIDTH-1:0] ret_count_q;

    logic                     in_fetch;
    logic                     in_mem_wr;
    logic                     fetch_done;
    logic                     retire_now;

    // Handshake-qualified outputs: these depend on this cycle's mem_ready.
    always_comb begin
        in_fetch   = (state == S_FETCH);
        in_mem_wr  = (state == S_MEM_WR);
        fetch_done = in_fetch & bus.mem_ready;
        retire_now = retire_q | (in_mem_wr & bus.mem_ready);
    end

    // Next-state selection: decode dispatch and memory stalls.
    always_comb begin
        next_state = state;
        case (state)
            S_RESET:    next_state = S_FETCH;
            S_FETCH:    next_state = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LOAD, OP_STORE: next_state = S_MEM_ADDR;
                    OP_RTYPE:          next_state = S_EXEC_R;
                    OP_ITYPE:          next_state = S_EXEC_I;
                    OP_BRANCH:         next_state = S_BRANCH;
                    OP_JAL:            next_state = S_JAL;
                    OP_JALR:           next_state = S_JALR;
                    OP_LUI, OP_AUIPC:  next_state = S_UPPER;
                    default:           next_state = S_TRAP;
                endcase
            end
            S_MEM_ADDR: next_state = (bus.opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   next_state = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:   next_state = S_FETCH;
            S_MEM_WR:   next_state = bus.mem_ready ? S_FETCH : S_MEM_WR;
            S_EXEC_R:   next_state = S_ALU_WB;
            S_EXEC_I:   next_state = S_ALU_WB;
            S_UPPER:    next_state = S_ALU_WB;
            S_ALU_WB:   next_state = S_FETCH;
            S_BRANCH:   next_state = S_FETCH;
            S_JAL:      next_state = S_FETCH;
            S_JALR:     next_state = S_FETCH;
            S_TRAP:     next_state = S_TRAP;
            default:    next_state = S_RESET;
        endcase
    end

    // State register, sticky illegal flag, retire counter and registered
    // Moore decode of the state about to be entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_RESET;
            illegal_q       <= 1'b0;
            ret_count_q     <= '0;
            alu_op_q        <= 2'd0;
            src_a_q         <= 2'd0;
            src_b_q         <= 2'd0;
            pc_source_q     <= 2'd0;
            pc_write_q      <= 1'b0;
            pc_write_cond_q <= 1'b0;
            i_or_d_q        <= 1'b0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            reg_write_q     <= 1'b0;
            mem_to_reg_q    <= 2'd0;
            retire_q        <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state == S_TRAP) begin
                illegal_q <= 1'b1;
            end
            if (retire_now) begin
                ret_count_q <= ret_count_q + 1'b1;
            end

            alu_op_q        <= 2'd0;
            src_a_q         <= 2'd0;
            src_b_q         <= 2'd0;
            pc_source_q     <= 2'd0;
            pc_write_q      <= 1'b0;
            pc_write_cond_q <= 1'b0;
            i_or_d_q        <= 1'b0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            reg_write_q     <= 1'b0;
            mem_to_reg_q    <= 2'd0;
            retire_q        <= 1'b0;

            case (next_state)
                S_FETCH: begin
                    mem_read_q <= 1'b1;
                    src_b_q    <= 2'd1;
                end
                S_DECODE: begin
                    src_b_q <= 2'd2;
                end
                S_MEM_ADDR: begin
                    src_a_q <= 2'd1;
                    src_b_q <= 2'd2;
                end
                S_MEM_RD: begin
                    mem_read_q <= 1'b1;
                    i_or_d_q   <= 1'b1;
                end
                S_MEM_WB: begin
                    reg_write_q  <= 1'b1;
                    mem_to_reg_q <= 2'd1;
                    retire_q     <= 1'b1;
                end
                S_MEM_WR: begin
                    mem_write_q <= 1'b1;
                    i_or_d_q    <= 1'b1;
                end
                S_EXEC_R: begin
                    src_a_q  <= 2'd1;
                    alu_op_q <= 2'b10;
                end
                S_EXEC_I: begin
                    src_a_q  <= 2'd1;
                    src_b_q  <= 2'd2;
                    alu_op_q <= 2'b11;
                end
                S_UPPER: begin
                    // LUI adds the immediate to zero, AUIPC to the PC.
                    src_a_q <= (bus.opcode == OP_LUI) ? 2'd2 : 2'd0;
                    src_b_q <= 2'd2;
                end
                S_ALU_WB: begin
                    reg_write_q <= 1'b1;
                    retire_q    <= 1'b1;
                end
                S_BRANCH: begin
                    src_a_q         <= 2'd1;
                    alu_op_q        <= 2'b01;
                    pc_write_cond_q <= 1'b1;
                    pc_source_q     <= 2'd1;
                    retire_q        <= 1'b1;
                end
                S_JAL: begin
                    pc_write_q   <= 1'b1;
                    pc_source_q  <= 2'd1;
                    reg_write_q  <= 1'b1;
                    mem_to_reg_q <= 2'd2;
                    retire_q     <= 1'b1;
                end
                S_JALR: begin
                    src_a_q      <= 2'd1;
                    src_b_q      <= 2'd2;
                    pc_write_q   <= 1'b1;
                    pc_source_q  <= 2'd2;
                    reg_write_q  <= 1'b1;
                    mem_to_reg_q <= 2'd2;
                    retire_q     <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.alu_op        = alu_op_q;
    assign bus.alu_src_a     = src_a_q;
    assign bus.alu_src_b     = src_b_q;
    assign bus.pc_source     = pc_source_q;
    assign bus.pc_write      = pc_write_q | fetch_done;
    assign bus.pc_write_cond = pc_write_cond_q;
    assign bus.i_or_d        = i_or_d_q;
    assign bus.mem_read      = mem_read_q;
    assign bus.mem_write     = mem_write_q;
    assign bus.ir_write      = fetch_done;
    assign bus.reg_write     = reg_write_q;
    assign bus.mem_to_reg    = mem_to_reg_q;
    assign bus.illegal       = illegal_q;
    assign bus.retire        = retire_now;
    assign bus.ret_count     = ret_count_q;

endmodule
`default_nettype wire
